// File: rtl/reg_write_scoreboard.sv
// reg_write_scoreboard: per-register count of issued-but-unretired writers.
// ID increments the count of its destination, WB and flush kills decrement it.
// The hazard unit queries rs1/rs2 busy state. Register x0 is never tracked.
module reg_write_scoreboard #(
    parameter int NREG  = 32,
    parameter int CNT_W = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            issue_valid,
    input  logic            issue_we,
    input  logic [4:0]      issue_rd,
    input  logic            wb_valid,
    input  logic [4:0]      wb_rd,
    input  logic            kill0_valid,
    input  logic [4:0]      kill0_rd,
    input  logic            kill1_valid,
    input  logic [4:0]      kill1_rd,
    input  logic [4:0]      q_rs1,
    input  logic [4:0]      q_rs2,
    output logic            rs1_busy,
    output logic            rs2_busy,
    output logic            issue_block,
    output logic [NREG-1:0] busy_vec,
    output logic [6:0]      pending_total,
    output logic            err_underflow,
    output logic            err_overflow
);

    // Two guard bits above the counter: top bit flags a negative result,
    // the bit just above the counter flags a result past saturation.
    localparam int              SUM_W = CNT_W + 2;
    localparam logic [CNT_W-1:0] SAT  = {CNT_W{1'b1}};

    logic [CNT_W-1:0]        cnt_r   [NREG];
    logic [CNT_W-1:0]        next_s  [NREG];
    logic signed [SUM_W-1:0] sum_s   [NREG];
    logic [1:0]              dec_s   [NREG];
    logic [NREG-1:0]         inc_s;
    logic [NREG-1:0]         ovf_hit_s;
    logic [NREG-1:0]         unf_hit_s;
    logic [NREG-1:0]         busy_cur_s;
    logic [NREG-1:0]         busy_next_s;
    logic [6:0]              total_s;

    // Per-register next count: +issue -wb -kills, clamped with error detection.
    always_comb begin
        for (int i = 0; i < NREG; i++) begin
            inc_s[i]     = 1'b0;
            dec_s[i]     = 2'd0;
            sum_s[i]     = '0;
            next_s[i]    = '0;
            ovf_hit_s[i] = 1'b0;
            unf_hit_s[i] = 1'b0;
            if (i != 0) begin
                inc_s[i] = issue_valid & issue_we & (issue_rd == 5'(i));
                dec_s[i] = {1'b0, wb_valid    & (wb_rd    == 5'(i))}
                         + {1'b0, kill0_valid & (kill0_rd == 5'(i))}
                         + {1'b0, kill1_valid & (kill1_rd == 5'(i))};
                sum_s[i] = $signed({2'b00, cnt_r[i]})
                         + $signed({{(SUM_W-1){1'b0}}, inc_s[i]})
                         - $signed({{(SUM_W-2){1'b0}}, dec_s[i]});
                if (sum_s[i][SUM_W-1]) begin
                    unf_hit_s[i] = 1'b1;
                    next_s[i]    = '0;
                end else if (sum_s[i][CNT_W]) begin
                    ovf_hit_s[i] = 1'b1;
                    next_s[i]    = SAT;
                end else begin
                    next_s[i]    = sum_s[i][CNT_W-1:0];
                end
            end else begin
                // x0 stays zero and never raises an error
                next_s[i] = '0;
            end
        end
    end

    // Busy vectors for current and next state, and the post-update total.
    always_comb begin
        total_s = 7'd0;
        for (int i = 0; i < NREG; i++) begin
            busy_cur_s[i]  = (cnt_r[i] != '0);
            busy_next_s[i] = (next_s[i] != '0);
            total_s        = total_s + 7'(next_s[i]);
        end
    end

    // Query and issue-block outputs look only at the current counts.
    always_comb begin
        rs1_busy    = busy_cur_s[q_rs1];
        rs2_busy    = busy_cur_s[q_rs2];
        issue_block = (issue_rd != 5'd0) & (cnt_r[issue_rd] == SAT);
    end

    // State update; reset discards every pending count and the sticky errors.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                cnt_r[i] <= '0;
            end
            busy_vec      <= '0;
            pending_total <= 7'd0;
            err_underflow <= 1'b0;
            err_overflow  <= 1'b0;
        end else begin
            for (int i = 0; i < NREG; i++) begin
                cnt_r[i] <= next_s[i];
            end
            busy_vec      <= busy_next_s;
            pending_total <= total_s;
            err_underflow <= err_underflow | (|unf_hit_s);
            err_overflow  <= err_overflow  | (|ovf_hit_s);
        end
    end

endmodule

// File: tb/tb_reg_write_scoreboard.sv
// Scoreboard bench for reg_write_scoreboard: directed per-cycle stimulus pushes
// hand-computed expected outputs; a negedge monitor pops and compares.
module tb_reg_write_scoreboard;

    logic        clk = 1'b0;
    logic        rst;
    logic        issue_valid, issue_we, wb_valid, kill0_valid, kill1_valid;
    logic [4:0]  issue_rd, wb_rd, kill0_rd, kill1_rd, q_rs1, q_rs2;
    logic        rs1_busy, rs2_busy, issue_block, err_underflow, err_overflow;
    logic [31:0] busy_vec;
    logic [6:0]  pending_total;

    typedef struct {
        int          id;
        logic        rs1b;
        logic        rs2b;
        logic        blk;
        logic [31:0] bv;
        logic [6:0]  tot;
        logic        eu;
        logic        eo;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   step_id  = 0;

    reg_write_scoreboard #(.NREG(32), .CNT_W(2)) dut (
        .clk(clk), .rst(rst),
        .issue_valid(issue_valid), .issue_we(issue_we), .issue_rd(issue_rd),
        .wb_valid(wb_valid), .wb_rd(wb_rd),
        .kill0_valid(kill0_valid), .kill0_rd(kill0_rd),
        .kill1_valid(kill1_valid), .kill1_rd(kill1_rd),
        .q_rs1(q_rs1), .q_rs2(q_rs2),
        .rs1_busy(rs1_busy), .rs2_busy(rs2_busy), .issue_block(issue_block),
        .busy_vec(busy_vec), .pending_total(pending_total),
        .err_underflow(err_underflow), .err_overflow(err_overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int id, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s step %0d: got %h expected %h", name, id, act, expv);
        end
    endtask

    // Monitor: compare the outputs of each checked cycle at the falling edge.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check("rs1_busy",      e.id, {31'd0, rs1_busy},      {31'd0, e.rs1b});
            check("rs2_busy",      e.id, {31'd0, rs2_busy},      {31'd0, e.rs2b});
            check("issue_block",   e.id, {31'd0, issue_block},   {31'd0, e.blk});
            check("busy_vec",      e.id, busy_vec,               e.bv);
            check("pending_total", e.id, {25'd0, pending_total}, {25'd0, e.tot});
            check("err_underflow", e.id, {31'd0, err_underflow}, {31'd0, e.eu});
            check("err_overflow",  e.id, {31'd0, err_overflow},  {31'd0, e.eo});
        end
    end

    task automatic drive(input logic iv, input logic iwe, input logic [4:0] ird,
                         input logic wv, input logic [4:0] wrd,
                         input logic k0v, input logic [4:0] k0rd,
                         input logic k1v, input logic [4:0] k1rd,
                         input logic [4:0] q1, input logic [4:0] q2);
        issue_valid = iv;  issue_we = iwe; issue_rd = ird;
        wb_valid    = wv;  wb_rd    = wrd;
        kill0_valid = k0v; kill0_rd = k0rd;
        kill1_valid = k1v; kill1_rd = k1rd;
        q_rs1 = q1; q_rs2 = q2;
    endtask

    task automatic expect_out(input logic r1, input logic r2, input logic blk,
                              input logic [31:0] bv, input logic [6:0] tot,
                              input logic eu, input logic eo);
        exp_t e;
        step_id++;
        e.id = step_id; e.rs1b = r1; e.rs2b = r2; e.blk = blk;
        e.bv = bv; e.tot = tot; e.eu = eu; e.eo = eo;
        exp_q.push_back(e);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 5'd0);
        next_cycle();
        next_cycle();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 5'd0);
        do_reset();

        // Idle after reset, query x5
        drive(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd5, 5'd0);
        expect_out(1'b0, 1'b0, 1'b0, 32'h0, 7'd0, 1'b0, 1'b0); next_cycle();

        // Issue x5, retire it three cycles later; a non-writing issue to x6 in between
        drive(1'b1, 1'b1, 5'd5, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd5, 5'd0);
        expect_out(1'b0, 1'b0, 1'b0, 32'h0, 7'd0, 1'b0, 1'b0); next_cycle();
        drive(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd5, 5'd0);
        expect_out(1'b1, 1'b0, 1'b0, 32'h20, 7'd1, 1'b0, 1'b0); next_cycle();
        drive(1'b1, 1'b0, 5'd6, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd5, 5'd0);
        expect_out(1'b1, 1'b0, 1'b0, 32'h20, 7'd1, 1'b0, 1'b0); next_cycle();
        drive(1'b0, 1'b0, 5'd0, 1'b1, 5'd5, 1'b0, 5'd0, 1'b0, 5'd0, 5'd5, 5'd6);
        expect_out(1'b1, 1'b0, 1'b0, 32'h20, 7'd1, 1'b0, 1'b0); next_cycle();
        drive(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd5, 5'd0);
        expect_out(1'b0, 1'b0, 1'b0, 32'h0, 7'd0, 1'b0, 1'b0); next_cycle();

        // Saturate x7, force a fourth issue, then drain with wb + two kills
        drive(1'b1, 1'b1, 5'd7, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd7, 5'd5);
        expect_out(1'b0, 1'b0, 1'b0, 32'h0, 7'd0, 1'b0, 1'b0); next_cycle();
        expect_out(1'b1, 1'b0, 1'b0, 32'h80, 7'd1, 1'b0, 1'b0); next_cycle();
        expect_out(1'b1, 1'b0, 1'b0, 32'h80, 7'd2, 1'b0, 1'b0); next_cycle();
        expect_out(1'b1, 1'b0, 1'b1, 32'h80, 7'd3, 1'b0, 1'b0); next_cycle();
        drive(1'b0, 1'b0, 5'd7, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd7, 5'd5);
        expect_out(1'b1, 1'b0, 1'b1, 32'h80, 7'd3, 1'b0, 1'b1); next_cycle();
        drive(1'b0, 1'b0, 5'd7, 1'b1, 5'd7, 1'b1, 5'd7, 1'b1, 5'd7, 5'd7, 5'd5);
        expect_out(1'b1, 1'b0, 1'b1, 32'h80, 7'd3, 1'b0, 1'b1); next_cycle();
        drive(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd7, 5'd5);
        expect_out(1'b0, 1'b0, 1'b0, 32'h0, 7'd0, 1'b0, 1'b1); next_cycle();
        do_reset();

        // x9: issue with cnt=1 plus wb plus kill nets to 0, then an extra wb underflows
        drive(1'b1, 1'b1, 5'd9, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd9, 5'd0);
        expect_out(1'b0, 1'b0, 1'b0, 32'h0, 7'd0, 1'b0, 1'b0); next_cycle();
        drive(1'b1, 1'b1, 5'd9, 1'b1, 5'd9, 1'b1, 5'd9, 1'b0, 5'd0, 5'd9, 5'd0);
        expect_out(1'b1, 1'b0, 1'b0, 32'h200, 7'd1, 1'b0, 1'b0); next_cycle();
        drive(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd9, 5'd0);
        expect_out(1'b0, 1'b0, 1'b0, 32'h0, 7'd0, 1'b0, 1'b0); next_cycle();
        drive(1'b0, 1'b0, 5'd0, 1'b1, 5'd9, 1'b0, 5'd0, 1'b0, 5'd0, 5'd9, 5'd0);
        expect_out(1'b0, 1'b0, 1'b0, 32'h0, 7'd0, 1'b0, 1'b0); next_cycle();
        drive(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd9, 5'd0);
        expect_out(1'b0, 1'b0, 1'b0, 32'h0, 7'd0, 1'b1, 1'b0); next_cycle();

        // x10: saturated count with simultaneous issue and wb stays 3, no overflow
        drive(1'b1, 1'b1, 5'd10, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd9, 5'd10);
        expect_out(1'b0, 1'b0, 1'b0, 32'h0, 7'd0, 1'b1, 1'b0); next_cycle();
        expect_out(1'b0, 1'b1, 1'b0, 32'h400, 7'd1, 1'b1, 1'b0); next_cycle();
        expect_out(1'b0, 1'b1, 1'b0, 32'h400, 7'd2, 1'b1, 1'b0); next_cycle();
        drive(1'b1, 1'b1, 5'd10, 1'b1, 5'd10, 1'b0, 5'd0, 1'b0, 5'd0, 5'd9, 5'd10);
        expect_out(1'b0, 1'b1, 1'b1, 32'h400, 7'd3, 1'b1, 1'b0); next_cycle();
        drive(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd9, 5'd10);
        expect_out(1'b0, 1'b1, 1'b0, 32'h400, 7'd3, 1'b1, 1'b0); next_cycle();
        do_reset();

        // Events targeting x0 are ignored
        drive(1'b1, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 5'd0, 5'd0);
        expect_out(1'b0, 1'b0, 1'b0, 32'h0, 7'd0, 1'b0, 1'b0); next_cycle();
        drive(1'b0, 1'b0, 5'd0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 5'd0);
        expect_out(1'b0, 1'b0, 1'b0, 32'h0, 7'd0, 1'b0, 1'b0); next_cycle();
        drive(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 5'd0);
        expect_out(1'b0, 1'b0, 1'b0, 32'h0, 7'd0, 1'b0, 1'b0); next_cycle();

        // cnt[3]=2, cnt[4]=1, then rst together with an issue to x3
        drive(1'b1, 1'b1, 5'd3, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd3, 5'd4);
        expect_out(1'b0, 1'b0, 1'b0, 32'h0, 7'd0, 1'b0, 1'b0); next_cycle();
        expect_out(1'b1, 1'b0, 1'b0, 32'h8, 7'd1, 1'b0, 1'b0); next_cycle();
        drive(1'b1, 1'b1, 5'd4, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd3, 5'd4);
        expect_out(1'b1, 1'b0, 1'b0, 32'h8, 7'd2, 1'b0, 1'b0); next_cycle();
        rst = 1'b1;
        drive(1'b1, 1'b1, 5'd3, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd3, 5'd4);
        expect_out(1'b1, 1'b1, 1'b0, 32'h18, 7'd3, 1'b0, 1'b0); next_cycle();
        rst = 1'b0;
        drive(1'b0, 1'b0, 5'd3, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd3, 5'd4);
        expect_out(1'b0, 1'b0, 1'b0, 32'h0, 7'd0, 1'b0, 1'b0); next_cycle();

        // Bounded drain of the scoreboard queue
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
            next_cycle();
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
